// File: rtl/uart_baud_gen.sv
// UART baud/oversample tick generator with a fractional (carry-accumulator) divider.
// Emits a one-cycle oversample strobe, a one-cycle baud strobe and a 50%-duty baud clock.
module uart_baud_gen #(
    parameter int unsigned DIV_WIDTH    = 16,
    parameter int unsigned FRAC_WIDTH   = 4,
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned DIV_INT_RST  = 10,
    parameter int unsigned DIV_FRAC_RST = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  restart,
    input  logic                  div_load,
    input  logic [DIV_WIDTH-1:0]  div_int_in,
    input  logic [FRAC_WIDTH-1:0] div_frac_in,
    output logic                  tick_os,
    output logic                  tick_baud,
    output logic                  baud_clk,
    output logic                  cfg_err
);

    localparam int unsigned OSW = $clog2(OVERSAMPLE);
    localparam logic [OSW-1:0]        OS_LAST  = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0]        OS_HALF  = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [OSW-1:0]        OS_ONE   = OSW'(1);
    localparam logic [DIV_WIDTH-1:0]  INT_RST  = DIV_WIDTH'(DIV_INT_RST);
    localparam logic [FRAC_WIDTH-1:0] FRAC_RST = FRAC_WIDTH'(DIV_FRAC_RST);
    localparam logic [DIV_WIDTH-1:0]  TWO      = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH:0]    CNT_ONE  = (DIV_WIDTH + 1)'(1);

    logic [DIV_WIDTH:0]      cnt_q, cnt_d;
    logic [OSW-1:0]          os_q, os_d;
    logic [FRAC_WIDTH-1:0]   acc_q, acc_d;
    logic                    carry_q, carry_d;
    logic [DIV_WIDTH-1:0]    act_int_q, act_int_d, sh_int_q, sh_int_d;
    logic [FRAC_WIDTH-1:0]   act_frac_q, act_frac_d, sh_frac_q, sh_frac_d;
    logic                    tick_os_q, tick_os_d;
    logic                    tick_baud_q, tick_baud_d;
    logic                    baud_clk_q, baud_clk_d;
    logic                    cfg_err_q, cfg_err_d;

    logic [DIV_WIDTH-1:0]    eff_int;
    logic [DIV_WIDTH:0]      period_len, period_last;
    logic [FRAC_WIDTH:0]     acc_sum;
    logic [DIV_WIDTH-1:0]    next_int;
    logic [FRAC_WIDTH-1:0]   next_frac;

    always_comb begin
        cnt_d       = cnt_q;
        os_d        = os_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        act_int_d   = act_int_q;
        act_frac_d  = act_frac_q;
        sh_int_d    = sh_int_q;
        sh_frac_d   = sh_frac_q;
        tick_os_d   = 1'b0;
        tick_baud_d = 1'b0;
        baud_clk_d  = baud_clk_q;

        eff_int     = (act_int_q < TWO) ? TWO : act_int_q;
        period_len  = {1'b0, eff_int} + {{DIV_WIDTH{1'b0}}, carry_q};
        period_last = period_len - CNT_ONE;
        acc_sum     = {1'b0, acc_q} + {1'b0, act_frac_q};

        // A load coinciding with a boundary is forwarded so the next period already uses it
        next_int  = div_load ? div_int_in  : sh_int_q;
        next_frac = div_load ? div_frac_in : sh_frac_q;
        if (div_load) begin
            sh_int_d  = div_int_in;
            sh_frac_d = div_frac_in;
        end

        if (restart) begin
            cnt_d      = '0;
            os_d       = '0;
            acc_d      = '0;
            carry_d    = 1'b0;
            baud_clk_d = 1'b1;
            act_int_d  = next_int;
            act_frac_d = next_frac;
        end else if (!enable) begin
            if (div_load) begin
                act_int_d  = div_int_in;
                act_frac_d = div_frac_in;
            end
        end else if (cnt_q >= period_last) begin
            // >= so an immediate divisor shrink while frozen ends the period instead of wrapping
            cnt_d       = '0;
            tick_os_d   = 1'b1;
            tick_baud_d = (os_q == OS_LAST);
            os_d        = (os_q == OS_LAST) ? '0 : os_q + OS_ONE;
            if (os_q == OS_HALF || os_q == OS_LAST) begin
                baud_clk_d = ~baud_clk_q;
            end
            acc_d      = acc_sum[FRAC_WIDTH-1:0];
            carry_d    = acc_sum[FRAC_WIDTH];
            act_int_d  = next_int;
            act_frac_d = next_frac;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        cfg_err_d = (act_int_d < TWO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            os_q        <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            act_int_q   <= INT_RST;
            act_frac_q  <= FRAC_RST;
            sh_int_q    <= INT_RST;
            sh_frac_q   <= FRAC_RST;
            tick_os_q   <= 1'b0;
            tick_baud_q <= 1'b0;
            baud_clk_q  <= 1'b1;
            cfg_err_q   <= (INT_RST < TWO);
        end else begin
            cnt_q       <= cnt_d;
            os_q        <= os_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            act_int_q   <= act_int_d;
            act_frac_q  <= act_frac_d;
            sh_int_q    <= sh_int_d;
            sh_frac_q   <= sh_frac_d;
            tick_os_q   <= tick_os_d;
            tick_baud_q <= tick_baud_d;
            baud_clk_q  <= baud_clk_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign tick_os   = tick_os_q;
    assign tick_baud = tick_baud_q;
    assign baud_clk  = baud_clk_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Scoreboard bench for uart_baud_gen: each scenario pushes the cycle numbers at which
// tick_os must fire; a monitor thread pops and checks timing, tick_baud and baud_clk.
module tb_uart_baud_gen;

    localparam int unsigned DW = 16;
    localparam int unsigned FW = 4;
    localparam int unsigned OS = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          restart = 1'b0;
    logic          div_load = 1'b0;
    logic [DW-1:0] div_int_in = '0;
    logic [FW-1:0] div_frac_in = '0;
    logic          tick_os, tick_baud, baud_clk, cfg_err;

    typedef struct {
        int unsigned cyc;
        logic        baud;
        logic        bclk;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fails = 0;
    int unsigned exp_os = 0;
    logic        exp_bclk = 1'b1;

    uart_baud_gen #(
        .DIV_WIDTH(DW), .FRAC_WIDTH(FW), .OVERSAMPLE(OS),
        .DIV_INT_RST(10), .DIV_FRAC_RST(0)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .restart(restart),
        .div_load(div_load), .div_int_in(div_int_in), .div_frac_in(div_frac_in),
        .tick_os(tick_os), .tick_baud(tick_baud), .baud_clk(baud_clk), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    function automatic void push_tick(input int unsigned at);
        exp_t e;
        e.cyc  = at;
        e.baud = (exp_os == OS - 1);
        if (exp_os == OS / 2 - 1 || exp_os == OS - 1) exp_bclk = ~exp_bclk;
        e.bclk = exp_bclk;
        exp_os = (exp_os + 1) % OS;
        sb.push_back(e);
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_checks++;
                n_fails++;
                $display("FAIL missed_tick: no tick_os at cycle %0d, required one there", sb[0].cyc);
                void'(sb.pop_front());
            end
            if (tick_os === 1'b1) begin
                n_checks++;
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    n_fails++;
                    $display("FAIL tick_os_timing: tick at cycle %0d, required next tick at cycle %0d",
                             cyc, (sb.size() > 0) ? sb[0].cyc : 0);
                end else begin
                    e = sb.pop_front();
                    n_checks++;
                    if (tick_baud !== e.baud) begin
                        n_fails++;
                        $display("FAIL tick_baud: cycle %0d got %b, required %b", cyc, tick_baud, e.baud);
                    end
                    n_checks++;
                    if (baud_clk !== e.bclk) begin
                        n_fails++;
                        $display("FAIL baud_clk: cycle %0d got %b, required %b", cyc, baud_clk, e.bclk);
                    end
                end
            end else begin
                n_checks++;
                if (tick_baud !== 1'b0) begin
                    n_fails++;
                    $display("FAIL tick_baud_alone: cycle %0d got %b, required 0", cyc, tick_baud);
                end
            end
        end
    endtask

    task automatic wait_to(input int unsigned target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; restart = 1'b0; div_load = 1'b0;
        div_int_in = '0; div_frac_in = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_os = 0;
        exp_bclk = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (tick_os !== 1'b0) begin n_fails++; $display("FAIL reset_tick_os: got %b, required 0", tick_os); end
        n_checks++; if (tick_baud !== 1'b0) begin n_fails++; $display("FAIL reset_tick_baud: got %b, required 0", tick_baud); end
        n_checks++; if (baud_clk !== 1'b1) begin n_fails++; $display("FAIL reset_baud_clk: got %b, required 1", baud_clk); end
        n_checks++; if (cfg_err !== 1'b0) begin n_fails++; $display("FAIL reset_cfg_err: got %b, required 0", cfg_err); end
    endtask

    task automatic test_default();
        int unsigned c0, hi;
        do_reset();
        enable = 1'b1;
        c0 = cyc;
        for (int k = 1; k <= 32; k++) push_tick(c0 + 10 * k);
        hi = 0;
        while (cyc < c0 + 160) begin
            @(negedge clk);
            if (baud_clk === 1'b1) hi++;
        end
        n_checks++; if (hi != 80) begin n_fails++; $display("FAIL default_baud_high: got %0d cycles, required 80", hi); end
        wait_to(c0 + 321);
        n_checks++; if (sb.size() != 0) begin n_fails++; $display("FAIL default_pending: got %0d, required 0", sb.size()); end
        enable = 1'b0;
    endtask

    task automatic test_frac();
        int unsigned c0, t, acc, c, s;
        do_reset();
        div_int_in = 16'd4; div_frac_in = 4'd8; div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0; enable = 1'b1;
        c0 = cyc; t = c0; acc = 0; c = 0;
        for (int k = 1; k <= 32; k++) begin
            t += 4 + c;
            push_tick(t);
            s = acc + 8;
            c = s / 16;
            acc = s % 16;
        end
        wait_to(c0 + 144);
        n_checks++; if (sb.size() != 0) begin n_fails++; $display("FAIL frac_pending: got %0d, required 0", sb.size()); end
        enable = 1'b0;
    endtask

    task automatic test_update();
        int unsigned c0;
        do_reset();
        enable = 1'b1;
        c0 = cyc;
        push_tick(c0 + 10);
        for (int k = 1; k <= 9; k++) push_tick(c0 + 10 + 6 * k);
        repeat (3) @(negedge clk);
        div_int_in = 16'd6; div_frac_in = '0; div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        wait_to(c0 + 65);
        n_checks++; if (sb.size() != 0) begin n_fails++; $display("FAIL update_pending: got %0d, required 0", sb.size()); end
        enable = 1'b0;
    endtask

    task automatic test_enable();
        int unsigned c0;
        do_reset();
        enable = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 20; k++) push_tick(c0 + 17 + 10 * k);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            n_checks++; if (tick_os !== 1'b0) begin n_fails++; $display("FAIL frozen_tick_os: got %b, required 0", tick_os); end
        end
        n_checks++; if (baud_clk !== 1'b1) begin n_fails++; $display("FAIL frozen_baud_clk: got %b, required 1", baud_clk); end
        enable = 1'b1;
        wait_to(c0 + 208);
        n_checks++; if (sb.size() != 0) begin n_fails++; $display("FAIL enable_pending: got %0d, required 0", sb.size()); end
        enable = 1'b0;
    endtask

    task automatic test_restart();
        int unsigned c0;
        do_reset();
        enable = 1'b1;
        c0 = cyc;
        for (int k = 1; k <= 5; k++) push_tick(c0 + 10 * k);
        wait_to(c0 + 53);
        restart = 1'b1;
        @(negedge clk);
        n_checks++; if (tick_os !== 1'b0) begin n_fails++; $display("FAIL restart1_tick_os: got %b, required 0", tick_os); end
        n_checks++; if (tick_baud !== 1'b0) begin n_fails++; $display("FAIL restart1_tick_baud: got %b, required 0", tick_baud); end
        n_checks++; if (baud_clk !== 1'b1) begin n_fails++; $display("FAIL restart1_baud_clk: got %b, required 1", baud_clk); end
        restart = 1'b0;
        exp_os = 0; exp_bclk = 1'b1;
        for (int k = 0; k < 10; k++) push_tick(c0 + 64 + 10 * k);
        wait_to(c0 + 157);
        n_checks++; if (baud_clk !== 1'b0) begin n_fails++; $display("FAIL pre_restart_baud_clk: got %b, required 0", baud_clk); end
        restart = 1'b1;
        @(negedge clk);
        n_checks++; if (tick_os !== 1'b0) begin n_fails++; $display("FAIL restart2_tick_os: got %b, required 0", tick_os); end
        n_checks++; if (baud_clk !== 1'b1) begin n_fails++; $display("FAIL restart2_baud_clk: got %b, required 1", baud_clk); end
        restart = 1'b0;
        exp_os = 0; exp_bclk = 1'b1;
        for (int k = 0; k < 16; k++) push_tick(c0 + 168 + 10 * k);
        wait_to(c0 + 319);
        n_checks++; if (sb.size() != 0) begin n_fails++; $display("FAIL restart_pending: got %0d, required 0", sb.size()); end
        enable = 1'b0;
    endtask

    task automatic test_cfg_err();
        int unsigned c0;
        int unsigned gaps[8] = '{2, 4, 6, 8, 11, 14, 17, 20};
        do_reset();
        div_int_in = 16'd1; div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        n_checks++; if (cfg_err !== 1'b1) begin n_fails++; $display("FAIL cfg_err_int1: got %b, required 1", cfg_err); end
        div_int_in = 16'd0; div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        n_checks++; if (cfg_err !== 1'b1) begin n_fails++; $display("FAIL cfg_err_int0: got %b, required 1", cfg_err); end
        enable = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 8; k++) push_tick(c0 + gaps[k]);
        wait_to(c0 + 6);
        div_int_in = 16'd3; div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        n_checks++; if (cfg_err !== 1'b1) begin n_fails++; $display("FAIL cfg_err_before_boundary: got %b, required 1", cfg_err); end
        @(negedge clk);
        n_checks++; if (cfg_err !== 1'b0) begin n_fails++; $display("FAIL cfg_err_after_boundary: got %b, required 0", cfg_err); end
        wait_to(c0 + 20);
        div_int_in = 16'd5; div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0; reset = 1'b1;
        @(negedge clk);
        n_checks++; if (tick_os !== 1'b0) begin n_fails++; $display("FAIL midreset_tick_os: got %b, required 0", tick_os); end
        n_checks++; if (tick_baud !== 1'b0) begin n_fails++; $display("FAIL midreset_tick_baud: got %b, required 0", tick_baud); end
        n_checks++; if (baud_clk !== 1'b1) begin n_fails++; $display("FAIL midreset_baud_clk: got %b, required 1", baud_clk); end
        n_checks++; if (cfg_err !== 1'b0) begin n_fails++; $display("FAIL midreset_cfg_err: got %b, required 0", cfg_err); end
        reset = 1'b0;
        exp_os = 0; exp_bclk = 1'b1;
        push_tick(c0 + 32);
        push_tick(c0 + 42);
        wait_to(c0 + 43);
        n_checks++; if (sb.size() != 0) begin n_fails++; $display("FAIL cfg_pending: got %0d, required 0", sb.size()); end
        enable = 1'b0;
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_default();
        test_frac();
        test_update();
        test_enable();
        test_restart();
        test_cfg_err();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
